// File: rtl/lfsr_rr_scheduler.sv
// Round-robin scheduler sharing one Fibonacci LFSR among NREQ requesters.
// Each grant delivers a fresh LENGTH-bit word produced by STEPS serial shifts.
module lfsr_rr_scheduler #(
  parameter int unsigned       LENGTH = 16,
  parameter logic [LENGTH-1:0] TAPS   = LENGTH'(53256),
  parameter int unsigned       NREQ   = 4,
  parameter int unsigned       STEPS  = LENGTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_load,
  input  logic [LENGTH-1:0] seed,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   gnt,
  output logic [LENGTH-1:0] rnd_data,
  output logic              rnd_valid,
  output logic              busy,
  output logic              lockup
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CntW = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StGrant} state_e;

  state_e            state_q;
  logic [LENGTH-1:0] lfsr_q;
  logic [LENGTH-1:0] lfsr_shift;
  logic [PtrW-1:0]   rr_ptr_q;
  logic [PtrW-1:0]   win_q;
  logic [CntW-1:0]   cnt_q;
  logic [PtrW-1:0]   hi_idx;
  logic [PtrW-1:0]   lo_idx;
  logic              hi_found;
  logic [PtrW-1:0]   win_idx;

  always_comb begin
    lfsr_shift = {lfsr_q[LENGTH-2:0], ^(lfsr_q & TAPS)};
  end

  // Round-robin: lowest requester at or above rr_ptr wins, else wrap to the lowest overall.
  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    hi_found = 1'b0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (req[j]) begin
        lo_idx = PtrW'(j);
        if (PtrW'(j) >= rr_ptr_q) begin
          hi_idx   = PtrW'(j);
          hi_found = 1'b1;
        end
      end
    end
    win_idx = hi_found ? hi_idx : lo_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      lfsr_q    <= LENGTH'(1);
      rr_ptr_q  <= '0;
      win_q     <= '0;
      cnt_q     <= '0;
      gnt       <= '0;
      rnd_data  <= '0;
      rnd_valid <= 1'b0;
      busy      <= 1'b0;
      lockup    <= 1'b0;
    end else begin
      gnt       <= '0;
      rnd_valid <= 1'b0;
      lockup    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (seed_load) begin
            // An all-zero seed would freeze the LFSR, so substitute 1 and flag it.
            if (seed == '0) begin
              lfsr_q <= LENGTH'(1);
              lockup <= 1'b1;
            end else begin
              lfsr_q <= seed;
            end
          end else if (|req) begin
            win_q   <= win_idx;
            cnt_q   <= CntW'(STEPS - 1);
            state_q <= StShift;
            busy    <= 1'b1;
          end
        end
        StShift: begin
          lfsr_q <= lfsr_shift;
          if (cnt_q == '0) begin
            rnd_data   <= lfsr_shift;
            gnt[win_q] <= 1'b1;
            rnd_valid  <= 1'b1;
            state_q    <= StGrant;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StGrant: begin
          rr_ptr_q <= (win_q == PtrW'(NREQ - 1)) ? '0 : win_q + 1'b1;
          state_q  <= StIdle;
          busy     <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_rr_scheduler.sv
// Directed bench for lfsr_rr_scheduler: scoreboard of expected grants/words against
// a reference LFSR model, checked with immediate assertions.
module tb_lfsr_rr_scheduler;

  localparam int unsigned LENGTH = 16;
  localparam int unsigned NREQ   = 4;
  localparam int unsigned STEPS  = 16;

  logic              clk       = 1'b0;
  logic              rst       = 1'b1;
  logic              seed_load = 1'b0;
  logic [LENGTH-1:0] seed      = '0;
  logic [NREQ-1:0]   req       = '0;
  logic [NREQ-1:0]   gnt;
  logic [LENGTH-1:0] rnd_data;
  logic              rnd_valid;
  logic              busy;
  logic              lockup;

  typedef struct packed {
    logic [NREQ-1:0]   gnt;
    logic [LENGTH-1:0] data;
  } exp_t;

  exp_t              sb[$];
  int                n_checks = 0;
  int                n_fail   = 0;
  logic [LENGTH-1:0] mdl;
  int                lat;

  lfsr_rr_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .seed_load (seed_load),
    .seed      (seed),
    .req       (req),
    .gnt       (gnt),
    .rnd_data  (rnd_data),
    .rnd_valid (rnd_valid),
    .busy      (busy),
    .lockup    (lockup)
  );

  always #5 clk = ~clk;

  function automatic logic [LENGTH-1:0] lfsr_next(input logic [LENGTH-1:0] s);
    return {s[LENGTH-2:0], ^(s & 16'hD008)};
  endfunction

  function automatic logic [LENGTH-1:0] word_after(input logic [LENGTH-1:0] s);
    logic [LENGTH-1:0] t;
    t = s;
    for (int i = 0; i < STEPS; i++) t = lfsr_next(t);
    return t;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for rnd_valid, then pops and compares the scoreboard head.
  task automatic wait_grant(input string tag, input int budget, output int lat_o);
    exp_t e;
    logic stray;
    stray = 1'b0;
    lat_o = 0;
    do begin
      @(negedge clk);
      lat_o++;
      if (rnd_valid !== 1'b1 && gnt !== '0) stray = 1'b1;
    end while (rnd_valid !== 1'b1 && lat_o < budget);
    check({tag, "_stray_gnt"}, 32'(stray), 0);
    check({tag, "_sb_depth"}, sb.size(), 1);
    check({tag, "_valid"}, 32'(rnd_valid), 1);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    check({tag, "_gnt"}, 32'(gnt), 32'(e.gnt));
    check({tag, "_data"}, 32'(rnd_data), 32'(e.data));
    check({tag, "_nonzero"}, 32'(rnd_data != '0), 1);
    check({tag, "_busy"}, 32'(busy), 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_valid", 32'(rnd_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_lockup", 32'(lockup), 0);
    check("rst_data", 32'(rnd_data), 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: all requesters held, grants rotate every STEPS+2 cycles
    seed      = 16'h0001;
    seed_load = 1'b1;
    @(negedge clk);
    check("t1_lockup", 32'(lockup), 0);
    check("t1_busy_idle", 32'(busy), 0);
    seed_load = 1'b0;
    req       = 4'b1111;
    mdl       = 16'h0001;
    for (int k = 0; k < 5; k++) begin
      mdl = word_after(mdl);
      sb.push_back({4'b0001 << (k % 4), mdl});
      wait_grant("t1", 40, lat);
      check("t1_lat", lat, (k == 0) ? 17 : 18);
    end
    req = '0;

    // 2: single requester, fixed latency
    @(negedge clk);
    seed      = 16'h0001;
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    req       = 4'b0100;
    sb.push_back({4'b0100, word_after(16'h0001)});
    wait_grant("t2", 40, lat);
    check("t2_lat", lat, 17);
    req = '0;

    // 3: zero seed triggers lock-up recovery
    @(negedge clk);
    seed      = 16'h0000;
    seed_load = 1'b1;
    @(negedge clk);
    check("t3_lockup_pulse", 32'(lockup), 1);
    seed_load = 1'b0;
    @(negedge clk);
    check("t3_lockup_end", 32'(lockup), 0);
    req = 4'b0001;
    sb.push_back({4'b0001, word_after(16'h0001)});
    wait_grant("t3", 40, lat);
    check("t3_lat", lat, 17);
    req = '0;

    // 4: seed_load wins over req in the same cycle
    @(negedge clk);
    seed      = 16'hACE1;
    seed_load = 1'b1;
    req       = 4'b0001;
    @(negedge clk);
    check("t4_busy", 32'(busy), 0);
    check("t4_valid", 32'(rnd_valid), 0);
    seed_load = 1'b0;
    sb.push_back({4'b0001, word_after(16'hACE1)});
    wait_grant("t4", 40, lat);
    check("t4_lat", lat, 17);
    req = '0;

    // 5: asynchronous reset in the middle of a transaction
    @(negedge clk);
    req = 4'b0010;
    repeat (5) @(negedge clk);
    check("t5_busy_mid", 32'(busy), 1);
    #2;
    rst = 1'b1;
    req = '0;
    #1;
    check("t5_rst_gnt", 32'(gnt), 0);
    check("t5_rst_valid", 32'(rnd_valid), 0);
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_lockup", 32'(lockup), 0);
    check("t5_rst_data", 32'(rnd_data), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t5_idle_after", 32'(busy), 0);
    req = 4'b1001;
    sb.push_back({4'b0001, word_after(16'h0001)});
    wait_grant("t5", 40, lat);
    check("t5_lat", lat, 17);
    req = '0;

    // 6: long back-to-back run; seed_load during SHIFT must be ignored
    @(negedge clk);
    seed      = 16'h0001;
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    req       = 4'b0001;
    mdl       = 16'h0001;
    for (int k = 0; k < 300; k++) begin
      mdl = word_after(mdl);
      sb.push_back({4'b0001, mdl});
      if (k == 10) begin
        @(negedge clk);
        @(negedge clk);
        check("t6_busy_shift", 32'(busy), 1);
        seed      = 16'h1234;
        seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        wait_grant("t6", 40, lat);
        check("t6_lat_inj", lat, 15);
      end else begin
        wait_grant("t6", 40, lat);
        check("t6_lat", lat, (k == 0) ? 17 : 18);
      end
    end
    req = '0;
    repeat (4) @(negedge clk);
    check("t6_hold_data", 32'(rnd_data), 32'(mdl));
    check("t6_hold_valid", 32'(rnd_valid), 0);
    check("t6_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
